// File: rtl/ftdi_tx_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ftdi_tx_arbiter_pkg
// Shared definitions for the FTDI TX arbiter and related FTDI-side blocks:
// FSM state encodings, the default frame header base value, header field
// widths and the payload length clamp helper.
// No ports (package).
// ----------------------------------------------------------------------------
package ftdi_tx_arbiter_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR   = 3'd1;
    localparam logic [2:0] ST_LEN   = 3'd2;
    localparam logic [2:0] ST_FETCH = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Header byte = base | source index; the index occupies the low bits
    localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;
    localparam int         HDR_IDX_W        = 3;
    localparam int         HDR_BASE_W       = 8 - HDR_IDX_W;

    // Limit a requested payload length to the largest packet a source can hold
    function automatic logic [7:0] clamp_len(input logic [7:0] len,
                                             input logic [7:0] max_len);
        if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/ftdi_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// ftdi_tx_arbiter_if
// Byte-stream valid/ready handshake between the TX arbiter (master) and the
// FTDI FIFO writer (slave).
//   tx_data   master->slave  8  byte being offered
//   tx_valid  master->slave  1  tx_data is valid
//   tx_ready  slave->master  1  writer accepts the byte this cycle
// ----------------------------------------------------------------------------
interface ftdi_tx_arbiter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ftdi_tx_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: returns the first requesting index at or
// after the pointer, wrapping modulo pNumReq. The pointer register is owned
// by the parent.
//   iReq    in   pNumReq          request vector
//   iPtr    in   $clog2(pNumReq)  highest-priority index this round
//   oGrant  out  pNumReq          one-hot winner (all zero when no request)
//   oIdx    out  $clog2(pNumReq)  binary index of the winner
//   oAny    out  1                at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int pNumReq = 4
) (
    input  logic [pNumReq-1:0]         iReq,
    input  logic [$clog2(pNumReq)-1:0] iPtr,
    output logic [pNumReq-1:0]         oGrant,
    output logic [$clog2(pNumReq)-1:0] oIdx,
    output logic                       oAny
);
    localparam int IW = $clog2(pNumReq);

    int w_pos;

    // Scan from the pointer upward; the first hit wins and later hits are ignored
    always_comb begin
        oGrant = '0;
        oIdx   = '0;
        oAny   = 1'b0;
        w_pos  = 0;
        for (int k = 0; k < pNumReq; k++) begin
            w_pos = int'(iPtr) + k;
            if (w_pos >= pNumReq) begin
                w_pos = w_pos - pNumReq;
            end else begin
                w_pos = w_pos;
            end
            if (!oAny && iReq[w_pos]) begin
                oAny          = 1'b1;
                oGrant[w_pos] = 1'b1;
                oIdx          = IW'(w_pos);
            end else begin
                oAny = oAny;
            end
        end
    end

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// ----------------------------------------------------------------------------
// ftdi_tx_arbiter
// Shares the FTDI TX byte path between pNumReq packet sources. A source is
// picked round-robin and its packet is sent as: header, length, payload.
// Each payload byte is fetched from the source's registered-read RAM with a
// one-cycle wait, so payload moves at one byte per two cycles at best.
//   iClk      in   1                system clock
//   iRst      in   1                synchronous active-high reset
//   iReq      in   pNumReq          source i has a complete packet
//   iLen      in   pNumReq*8        payload length per source (byte i)
//   oGrant    out  pNumReq          one-hot grant, held for the frame
//   oRdAddr   out  $clog2(pMaxLen)  payload byte index into granted RAM
//   iRdData   in   pNumReq*8        RAM read data per source (1-cycle latency)
//   oDone     out  pNumReq          one-cycle pulse when source i's frame ends
//   tx        master modport        byte stream to the FTDI writer
//   oBusy     out  1                a frame is in progress
// ----------------------------------------------------------------------------
module ftdi_tx_arbiter
    import ftdi_tx_arbiter_pkg::*;
#(
    parameter int         pNumReq  = 4,
    parameter int         pMaxLen  = 16,
    parameter logic [7:0] pHdrBase = HDR_BASE_DEFAULT
) (
    input  logic                         iClk,
    input  logic                         iRst,
    input  logic [pNumReq-1:0]           iReq,
    input  logic [pNumReq*8-1:0]         iLen,
    output logic [pNumReq-1:0]           oGrant,
    output logic [$clog2(pMaxLen)-1:0]   oRdAddr,
    input  logic [pNumReq*8-1:0]         iRdData,
    output logic [pNumReq-1:0]           oDone,
    ftdi_tx_arbiter_if.master            tx,
    output logic                         oBusy
);
    localparam int IW = $clog2(pNumReq);
    localparam int AW = $clog2(pMaxLen);

    logic [2:0]         r_state;
    logic [pNumReq-1:0] r_grant;
    logic [IW-1:0]      r_idx;
    logic [IW-1:0]      r_ptr;
    logic [7:0]         r_len;
    logic [AW-1:0]      r_rd_addr;
    logic [pNumReq-1:0] r_done;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;

    logic [pNumReq-1:0] w_arb_grant;
    logic [IW-1:0]      w_arb_idx;
    logic               w_arb_any;
    logic [7:0]         w_req_len;
    logic [7:0]         w_rd_byte;
    logic               w_xfer;
    logic               w_last;

    rr_arbiter #(.pNumReq(pNumReq)) u_rr (
        .iReq   (iReq),
        .iPtr   (r_ptr),
        .oGrant (w_arb_grant),
        .oIdx   (w_arb_idx),
        .oAny   (w_arb_any)
    );

    assign w_req_len = iLen[8*int'(w_arb_idx) +: 8];
    assign w_rd_byte = iRdData[8*int'(r_idx) +: 8];
    assign w_xfer    = r_tx_valid && tx.tx_ready;
    assign w_last    = (8'(r_rd_addr) == (r_len - 8'd1));

    // The source RAM output register holds the payload byte for the whole
    // DATA state (its address only moves on transfer), so it is forwarded
    // directly rather than copied into a second register.
    assign tx.tx_data  = (r_state == ST_DATA) ? w_rd_byte : r_tx_data;
    assign tx.tx_valid = r_tx_valid;
    assign oGrant      = r_grant;
    assign oRdAddr     = r_rd_addr;
    assign oDone       = r_done;
    assign oBusy       = (r_state != ST_IDLE);

    // Frame sequencer: arbitration, header/length emission, payload fetch loop
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_idx      <= '0;
            r_ptr      <= '0;
            r_len      <= 8'd0;
            r_rd_addr  <= '0;
            r_done     <= '0;
            r_tx_data  <= 8'd0;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= '0;
                    if (w_arb_any) begin
                        r_grant    <= w_arb_grant;
                        r_idx      <= w_arb_idx;
                        r_len      <= clamp_len(w_req_len, 8'(pMaxLen));
                        r_tx_data  <= pHdrBase | 8'(w_arb_idx);
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_HDR;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HDR: begin
                    if (w_xfer) begin
                        r_tx_data <= r_len;
                        r_state   <= ST_LEN;
                    end else begin
                        r_state <= ST_HDR;
                    end
                end
                ST_LEN: begin
                    if (w_xfer) begin
                        r_tx_valid <= 1'b0;
                        if (r_len == 8'd0) begin
                            r_done  <= r_grant;
                            r_state <= ST_DONE;
                        end else begin
                            r_rd_addr <= '0;
                            r_state   <= ST_FETCH;
                        end
                    end else begin
                        r_state <= ST_LEN;
                    end
                end
                ST_FETCH: begin
                    // RAM sees the address this cycle; data is valid next cycle
                    r_tx_valid <= 1'b1;
                    r_state    <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_tx_valid <= 1'b0;
                        if (w_last) begin
                            r_done  <= r_grant;
                            r_state <= ST_DONE;
                        end else begin
                            r_rd_addr <= r_rd_addr + AW'(1);
                            r_state   <= ST_FETCH;
                        end
                    end else begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DONE: begin
                    r_done     <= '0;
                    r_grant    <= '0;
                    r_tx_valid <= 1'b0;
                    r_rd_addr  <= '0;
                    r_ptr      <= (r_idx == IW'(pNumReq - 1)) ? '0 : r_idx + IW'(1);
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_grant    <= '0;
                    r_done     <= '0;
                    r_tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ftdi_tx_arbiter
// Directed self-checking bench for ftdi_tx_arbiter (4 sources, 16-byte max).
// ----------------------------------------------------------------------------
module tb_ftdi_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  grant;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic [3:0]  done;
    logic        busy;

    logic [7:0]  ram [0:3][0:15];

    int checks;
    int errors;
    int done_cnt [0:3];
    int busy_cyc;

    logic [7:0] b;
    int         snap_busy;
    int         snap_d0;
    int         snap_d1;

    ftdi_tx_arbiter_if tx_if();

    ftdi_tx_arbiter #(.pNumReq(4), .pMaxLen(16), .pHdrBase(8'hA0)) dut (
        .iClk    (clk),
        .iRst    (rst),
        .iReq    (req),
        .iLen    (len),
        .oGrant  (grant),
        .oRdAddr (rd_addr),
        .iRdData (rd_data),
        .oDone   (done),
        .tx      (tx_if.master),
        .oBusy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source RAMs: registered read, one cycle of latency
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            rd_data[i*8 +: 8] <= ram[i][rd_addr];
        end
    end

    // Observation counters: oDone pulses per source and busy cycles
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done[i]) done_cnt[i] = done_cnt[i] + 1;
        end
        if (busy) busy_cyc = busy_cyc + 1;
    end

    initial begin
        for (int i = 0; i < 4; i++) done_cnt[i] = 0;
        busy_cyc = 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next accepted byte; returns just after the transfer edge
    task automatic next_byte(input string tag, output logic [7:0] v);
        bit got;
        got = 1'b0;
        v   = 8'hXX;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                v   = tx_if.tx_data;
                got = 1'b1;
            end
        end
        if (got) begin
            @(posedge clk);
        end else begin
            checks = checks + 1;
            errors = errors + 1;
            $error("FAIL %s timeout observed=no_byte expected=byte", tag);
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        next_byte(tag, v);
        chk(tag, 32'(v), 32'(exp));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        req = 4'b0000;
        len = 32'd0;
        tx_if.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 16; k++)
                ram[i][k] = 8'h00;

        // ---- reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_valid", 32'(tx_if.tx_valid), 32'h0);
        chk("rst_data",  32'(tx_if.tx_data), 32'h0);
        chk("rst_done",  32'(done), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_addr",  32'(rd_addr), 32'h0);
        rst = 1'b0;

        // ---- single source 1, len 3
        ram[1][0] = 8'h11; ram[1][1] = 8'h22; ram[1][2] = 8'h33;
        len[8 +: 8] = 8'd3;
        @(negedge clk);
        snap_busy = busy_cyc;
        req = 4'b0010;
        expect_byte("s1_hdr", 8'hA1);
        chk("s1_grant", 32'(grant), 32'h2);
        expect_byte("s1_len", 8'h03);
        expect_byte("s1_d0", 8'h11);
        expect_byte("s1_d1", 8'h22);
        expect_byte("s1_d2", 8'h33);
        @(negedge clk);
        chk("s1_done", 32'(done), 32'h2);
        req = 4'b0000;
        @(negedge clk);
        chk("s1_done_off", 32'(done), 32'h0);
        chk("s1_idle_busy", 32'(busy), 32'h0);
        chk("s1_grant_off", 32'(grant), 32'h0);
        chk("s1_busy_cycles", 32'(busy_cyc - snap_busy), 32'd9);
        chk("s1_done_count", 32'(done_cnt[1]), 32'd1);

        // ---- zero length on source 2, iReq dropped during LEN
        len[16 +: 8] = 8'd0;
        req = 4'b0100;
        expect_byte("z_hdr", 8'hA2);
        req = 4'b0000;
        expect_byte("z_len", 8'h00);
        @(negedge clk);
        chk("z_done", 32'(done), 32'h4);
        chk("z_valid", 32'(tx_if.tx_valid), 32'h0);
        @(negedge clk);
        chk("z_idle", 32'(busy), 32'h0);

        // ---- backpressure on source 3, len 2
        ram[3][0] = 8'h5A; ram[3][1] = 8'hC3;
        len[24 +: 8] = 8'd2;
        req = 4'b1000;
        expect_byte("bp_hdr", 8'hA3);
        expect_byte("bp_len", 8'h02);
        @(negedge clk);
        tx_if.tx_ready = 1'b0;
        for (int n = 0; n < 10 && !tx_if.tx_valid; n++) @(negedge clk);
        chk("bp_stall1_valid", 32'(tx_if.tx_valid), 32'h1);
        chk("bp_stall1_data", 32'(tx_if.tx_data), 32'h5A);
        @(negedge clk);
        chk("bp_stall2_valid", 32'(tx_if.tx_valid), 32'h1);
        chk("bp_stall2_data", 32'(tx_if.tx_data), 32'h5A);
        tx_if.tx_ready = 1'b1;
        @(posedge clk);
        expect_byte("bp_d1", 8'hC3);
        @(negedge clk);
        chk("bp_done", 32'(done), 32'h8);
        req = 4'b0000;
        @(negedge clk);

        // ---- all four requesting, len 1 each: cyclic order from pointer 0
        len = {8'd1, 8'd1, 8'd1, 8'd1};
        for (int i = 0; i < 4; i++) ram[i][0] = 8'h10 + 8'(i);
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            expect_byte("rr_hdr", 8'hA0 | 8'(f % 4));
            expect_byte("rr_len", 8'h01);
            expect_byte("rr_data", 8'h10 + 8'(f % 4));
        end
        @(negedge clk);
        chk("rr_done_src0", 32'(done), 32'h1);
        req = 4'b0000;
        @(negedge clk);

        // ---- oversize length on source 0: clamped to 16
        for (int k = 0; k < 16; k++) ram[0][k] = 8'h40 + 8'(k);
        len[0 +: 8] = 8'd40;
        req = 4'b0001;
        expect_byte("ov_hdr", 8'hA0);
        expect_byte("ov_len", 8'h10);
        for (int k = 0; k < 16; k++) expect_byte("ov_data", 8'h40 + 8'(k));
        @(negedge clk);
        chk("ov_done", 32'(done), 32'h1);
        chk("ov_no_extra", 32'(tx_if.tx_valid), 32'h0);
        req = 4'b0000;
        @(negedge clk);

        // ---- reset during 2nd payload byte; pointer returns to 0
        ram[0][0] = 8'h77;
        len[0 +: 8] = 8'd1;
        len[8 +: 8] = 8'd3;
        snap_d0 = done_cnt[0];
        snap_d1 = done_cnt[1];
        req = 4'b0011;
        expect_byte("rs_hdr_ptr1", 8'hA1);
        expect_byte("rs_len", 8'h03);
        expect_byte("rs_d0", 8'h11);
        @(negedge clk);
        @(negedge clk);
        chk("rs_d1_pending", 32'(tx_if.tx_data), 32'h22);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rs_grant", 32'(grant), 32'h0);
        chk("rs_valid", 32'(tx_if.tx_valid), 32'h0);
        chk("rs_data",  32'(tx_if.tx_data), 32'h0);
        chk("rs_done",  32'(done), 32'h0);
        chk("rs_busy",  32'(busy), 32'h0);
        chk("rs_addr",  32'(rd_addr), 32'h0);
        expect_byte("rs_hdr_src0", 8'hA0);
        expect_byte("rs_len0", 8'h01);
        expect_byte("rs_data0", 8'h77);
        @(negedge clk);
        chk("rs_done0", 32'(done), 32'h1);
        req = 4'b0000;
        @(negedge clk);
        chk("rs_no_done1", 32'(done_cnt[1] - snap_d1), 32'd0);
        chk("rs_done0_count", 32'(done_cnt[0] - snap_d0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
